shift_unit_iter: RTL
====================

# shift_unit_iter

Parametrised multi-cycle shifter for the ALU datapath. It generalises the fixed-amount shift stages into one block that takes any shift amount, offers logical-left, logical-right, arithmetic-right and optional rotate modes, and accepts any power-of-two width. It resolves one binary-weighted shift stage per clock (largest first), sits beside the adder/logic units behind a valid/ready handshake, and returns the result with fixed latency.

## Interface
- Parameters:
  - WIDTH, 32: operand width; power of two, ≥ 2.
  - SHAMT_W (localparam): $clog2(WIDTH); also the stage count.
- Ports:
  - clock  in  1: single clock; all state changes on the rising edge.
  - reset  in  1: asynchronous, active-high reset.
  - in_valid  in  1: operation offered.
  - in_ready  out  1: block can accept; high only in IDLE and while reset is low.
  - in_data  in  WIDTH: operand.
  - in_shamt  in  SHAMT_W: shift amount, 0..WIDTH-1.
  - in_op  in  2: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
  - out_valid  out  1: result available.
  - out_ready  in  1: consumer takes the result.
  - out_result  out  WIDTH: working/result register.
  - busy  out  1: high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high at an edge: latch in_data into the working register, latch in_shamt and in_op, latch sign = in_data[WIDTH-1], load stage counter k = SHAMT_W-1, go to SHIFT.
- SHIFT:
  - Each edge, if shamt[k] is set, shift the working register by 2^k per op:
    - SLL: fill with 0.
    - SRL: fill with 0.
    - SRA: fill with the latched sign.
    - ROR: wrap bits.
  - If shamt[k] is clear, hold the register.
  - Decrement k. The edge that processes k=0 moves to DONE.
- DONE:
  - out_valid=1; out_result stable.
  - An edge with out_ready=1 returns to IDLE and clears out_valid.
  - out_ready=0 holds DONE indefinitely.
- Inputs are ignored outside IDLE. in_data, in_shamt and in_op need not stay stable after the accept edge.
- shamt=0 passes the operand through unchanged, with the same latency.
- out_result changes during SHIFT and is meaningful only while out_valid=1. It holds its value through IDLE until the next accept.

## Timing
- Reset (async assert): state=IDLE, out_valid=0, busy=0, out_result=0, counter=0, in_ready=0 while reset is high.
- Reset mid-operation aborts immediately; no result is produced.
- Latency: accept at edge E; out_valid is high after edge E+SHAMT_W (edge E+5 for WIDTH=32).
- Throughput: at most one operation per SHAMT_W+2 cycles. in_ready is never high in the same cycle as out_valid.
- Simultaneous in_valid and out_ready in DONE: the result handshake completes. The new operand is not accepted until the following IDLE cycle.

## Configuration
- SHIFT_UNIT_ROTATE_EN:
  - Defined: op 11 performs rotate-right by shamt.
  - Undefined: op 11 executes exactly as SRL (zero fill), and no rotate muxing is synthesised.
  - All other ops are identical in both builds.

## Test plan
- SRA, in_data=0x80000000, shamt=8 -> out_result=0xFF800000; out_valid rises exactly 5 edges after accept.
- SLL, 0x00000001, shamt=31 -> 0x80000000. SRL, 0xF0000000, shamt=4 -> 0x0F000000.
- op 11, 0x12345678, shamt=8 -> 0x78123456 with SHIFT_UNIT_ROTATE_EN defined; 0x00123456 without it.
- shamt=0, SRA, 0xDEADBEEF -> 0xDEADBEEF, still 5-cycle latency.
- Hold out_ready=0 for 3 cycles in DONE -> out_valid and out_result stay stable and in_ready stays 0. Raise out_ready -> IDLE next edge, then a back-to-back accept works.
- Assert reset two cycles after accept -> out_valid=0, busy=0, out_result=0 immediately. After release, a new operation completes normally.
- WIDTH=8 instance: SRA, 0x90, shamt=3 -> 0xF2 after 3 edges.

Source files
------------

// File: rtl/shift_unit_iter_if.sv
// Handshake bus for shift_unit_iter: operand request channel, result channel and busy flag.
interface shift_unit_iter_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/shift_unit_iter.sv
// Iterative shifter: one binary-weighted stage per clock, largest stage first.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN enables rotate-right for op 11 (otherwise SRL).
module shift_unit_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  shift_unit_iter_if.slave  bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam logic [1:0]  OP_SLL  = 2'b00;
  localparam logic [1:0]  OP_SRA  = 2'b10;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [1:0]  OP_ROR  = 2'b11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [SHAMT_W-1:0] k_q, k_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   step_res;

  // Shift the working value by a constant amount; amt is always an unrolled constant.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] v,
                                                   input logic [1:0] op,
                                                   input logic sgn,
                                                   input int unsigned amt);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    ones = '1;
    case (op)
      OP_SLL:  res = v << amt;
      OP_SRA:  res = (v >> amt) | (sgn ? ~(ones >> amt) : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR:  res = (v >> amt) | (v << (WIDTH - amt));
`endif
      default: res = v >> amt;
    endcase
    return res;
  endfunction

  // Select the stage result for the current stage counter.
  always_comb begin
    step_res = work_q;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (k_q == SHAMT_W'(i)) step_res = stage_shift(work_q, op_q, sign_q, 1 << i);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    k_d     = k_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          shamt_d = bus.in_shamt;
          op_d    = bus.in_op;
          sign_d  = bus.in_data[WIDTH-1];
          k_d     = SHAMT_W'(SHAMT_W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shamt_q[k_q]) work_d = step_res;
        k_d = k_q - SHAMT_W'(1);
        if (k_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      shamt_q     <= '0;
      k_q         <= '0;
      op_q        <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      shamt_q     <= shamt_d;
      k_q         <= k_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // in_ready is masked by reset so it stays low for the whole reset pulse.
  assign bus.in_ready   = (state_q == S_IDLE) && !reset;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.out_result = work_q;
endmodule
